tcdm_stream_reader: RTL and testbench
=====================================

Name: tcdm_stream_reader

Overview:
TCDM initiator that fetches a strided sequence of 32-bit words over one TCDM master port. It delivers the words, in order, as a valid/ready output stream with a last flag. It is the requesting end of the single-port TCDM protocol that the testbench dummy memories and the cluster TCDM serve. It feeds streamer inputs of the SpMM datapath (sparse A indices/values, dense B rows).

Parameters:
FIFO_DEPTH, 4, response buffer entries; also caps in-flight plus buffered words; power of two, >=2
LEN_WIDTH, 16, width of transfer length in words
ADDR_WIDTH, 32, TCDM byte address width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  one-cycle start pulse; sampled only in IDLE
base_addr_i  in  ADDR_WIDTH  byte address of first word
stride_i  in  ADDR_WIDTH  byte increment between words, unsigned
len_i  in  LEN_WIDTH  number of words
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle completion pulse
tcdm_req_o  out  1  TCDM request
tcdm_gnt_i  in  1  TCDM grant
tcdm_add_o  out  ADDR_WIDTH  TCDM byte address
tcdm_wen_o  out  1  constant 1 (read)
tcdm_be_o  out  4  constant 4'hF
tcdm_data_o  out  32  constant 0
tcdm_r_data_i  in  32  response data
tcdm_r_valid_i  in  1  response valid; has no backpressure
data_o  out  32  stream data
valid_o  out  1  stream valid
ready_i  in  1  stream ready
last_o  out  1  high with the final word of the transfer
err_o  out  1  sticky protocol error (optional feature)

Behaviour:
- Reset values: busy_o=0, done_o=0, tcdm_req_o=0, tcdm_add_o=0, valid_o=0, last_o=0, err_o=0. FSM=IDLE, counters=0, FIFO empty.
- FSM states and transitions:
  - IDLE: on start_i, latch base, stride and len. If len=0, go to DONE; otherwise go to ISSUE.
  - ISSUE: issue requests. After the len-th grant, go to DRAIN.
  - DRAIN: wait for responses and stream output. After the last output handshake, go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- start_i outside IDLE is ignored.
- Address of word k = base + k*stride, modulo 2^ADDR_WIDTH (wraps silently). Implement with an incrementing address register, no multiplier.
- Request rules:
  - tcdm_req_o=1 in ISSUE only when outstanding + fifo_count < FIFO_DEPTH.
  - Once asserted, tcdm_req_o and tcdm_add_o are held stable until req&gnt is sampled high.
  - A grant advances the address in the same cycle, so back-to-back grants give one word per cycle.
- outstanding:
  - increments on req&gnt; decrements on r_valid.
  - Grant and r_valid in the same cycle leave it unchanged.
  - Never exceeds FIFO_DEPTH.
- Responses:
  - r_valid pushes r_data into the FIFO. The credit rule guarantees the push never meets a full FIFO.
  - Response data is assumed to arrive in grant order (single-port TCDM is in-order).
- Stream output:
  - valid_o = FIFO not empty; data_o = FIFO head.
  - Pop on valid_o&ready_i.
  - r_valid at cycle t gives valid_o at cycle t+1 at the earliest.
  - A simultaneous push and pop keeps the FIFO count unchanged.
  - data_o and last_o are held stable while valid_o&~ready_i.
- last_o = valid_o and output-beat counter == len-1.
- done_o is asserted in the cycle after the last output handshake.
- Reset mid-operation:
  - Everything clears; tcdm_req_o is low in the cycle after rst_i is sampled.
  - Responses arriving after reset are dropped (not pushed).

Optional Feature:
Macro TCDM_STREAM_READER_ERR_EN.
- Defined: err_o sets, and stays set until rst_i, when either of these occurs:
  - r_valid arrives with outstanding==0, including late responses after reset;
  - the FIFO would overflow.
  In both cases the response is dropped. An SVA assertion also checks req stability until grant.
- Not defined: err_o is tied to 0; no checker logic or assertions.

Test Plan:
- Basic read: base=0x100, stride=4, len=4, memory with 1-cycle response, gnt=1, ready=1 -> add_o sequence 0x100, 0x104, 0x108, 0x10C on consecutive cycles; data_o carries mem[0x40..0x43] in order; last_o only on the 4th beat; one done_o pulse; busy_o low afterwards.
- Grant stall: gnt_i=0 for 3 cycles while the 2nd request is pending -> req_o stays high with add_o=0x104 for those 3 cycles; no address skip and no duplicate.
- Backpressure: FIFO_DEPTH=4, len=10, ready_i=0 -> exactly 4 grants, then req_o low. Raising ready_i releases all 10 words in order with no loss; last_o on word 10.
- Zero length: start_i with len=0 -> no tcdm_req_o; done_o one cycle later; busy_o high for that 1 cycle only.
- Wrap and stride: base=0xFFFFFFF8, stride=8, len=3 -> addresses 0xFFFFFFF8, 0x00000000, 0x00000008.
- Reset mid-transfer with a late response: reset with 2 words outstanding, then r_valid pulses -> FIFO empty, valid_o=0. err_o=1 with TCDM_STREAM_READER_ERR_EN defined; err_o=0 without it.

Source files
------------

// File: rtl/tcdm_stream_reader.sv
// Strided TCDM word fetcher: issues credit-limited reads and streams the words out in order.
// Optional sticky protocol-error flag and request-stability assertion under TCDM_STREAM_READER_ERR_EN.
module tcdm_stream_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0] tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [3:0]            tcdm_be_o,
  output logic [31:0]           tcdm_data_o,
  input  logic [31:0]           tcdm_r_data_i,
  input  logic                  tcdm_r_valid_i,
  output logic [31:0]           data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  err_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // ISSUE | sending requests, streaming whatever has returned
  // DRAIN | all requests granted, waiting for the remaining words to leave
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] stride;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  beats;
  logic [CNT_W-1:0]      outstanding;

  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;

  logic grant;
  logic credit_ok;
  logic fifo_full;
  logic resp_ok;
  logic push;
  logic pop;
  logic last_issue;
  logic last_beat;
  logic accept_start;

  assign accept_start = (state == IDLE) && start_i;
  assign grant        = tcdm_req_o && tcdm_gnt_i;
  assign fifo_full    = (fifo_count == CNT_W'(FIFO_DEPTH));
  // Outstanding plus buffered words may never exceed the FIFO, so every response has a slot.
  assign credit_ok    = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign resp_ok      = tcdm_r_valid_i && (outstanding != '0);
  assign push         = resp_ok && !fifo_full;
  assign pop          = valid_o && ready_i;
  assign last_issue   = (issued == len - LEN_WIDTH'(1));
  assign last_beat    = (beats == len - LEN_WIDTH'(1));

  assign valid_o     = (fifo_count != '0);
  assign data_o      = fifo_mem[rd_ptr];
  assign last_o      = valid_o && last_beat;
  assign tcdm_add_o  = addr;
  assign tcdm_wen_o  = 1'b1;
  assign tcdm_be_o   = 4'hF;
  assign tcdm_data_o = 32'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_i) state_next = (len_i == '0) ? DONE : ISSUE;
      ISSUE:   if (grant && last_issue) state_next = DRAIN;
      DRAIN:   if (pop && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = 1'b0;
    done_o     = 1'b0;
    tcdm_req_o = 1'b0;
    unique case (state)
      IDLE:    ;
      ISSUE: begin
        busy_o     = 1'b1;
        tcdm_req_o = credit_ok;
      end
      DRAIN:   busy_o = 1'b1;
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Address walks by stride on each grant; wrap-around is modulo 2^ADDR_WIDTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr   <= '0;
      stride <= '0;
      len    <= '0;
      issued <= '0;
      beats  <= '0;
    end else if (accept_start) begin
      addr   <= base_addr_i;
      stride <= stride_i;
      len    <= len_i;
      issued <= '0;
      beats  <= '0;
    end else begin
      if (grant) begin
        addr   <= addr + stride;
        issued <= issued + LEN_WIDTH'(1);
      end
      if (pop) beats <= beats + LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      unique case ({grant, resp_ok})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= tcdm_r_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef TCDM_STREAM_READER_ERR_EN
  logic err;

  // Stray responses (nothing outstanding, e.g. after reset) and overflows are dropped and flagged.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                                   err <= 1'b0;
    else if (tcdm_r_valid_i && ((outstanding == '0) || fifo_full)) err <= 1'b1;
  end

  assign err_o = err;

  req_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (tcdm_req_o && !tcdm_gnt_i) |=> (tcdm_req_o && $stable(tcdm_add_o)));
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tcdm_stream_reader.sv
// Bench for tcdm_stream_reader: 1-cycle dummy TCDM, address/data scoreboards, directed scenarios.
module tb_tcdm_stream_reader;

  localparam int FIFO_DEPTH = 4;
  localparam int LEN_WIDTH  = 16;
  localparam int ADDR_WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] stride = '0;
  logic [15:0] len = '0;
  logic        busy, done, req, wen, valid, last, err;
  logic        gnt = 1'b0;
  logic [31:0] add, wdata, data;
  logic [3:0]  be;
  logic [31:0] r_data = '0;
  logic        r_valid = 1'b0;
  logic        ready = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int grant_cnt = 0;

  logic [31:0] exp_addr[$];
  logic [32:0] exp_beat[$];
  logic [31:0] resp_q[$];
  bit          resp_hold = 1'b0;

  always #5 clk = ~clk;

  tcdm_stream_reader #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .LEN_WIDTH (LEN_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .base_addr_i   (base_addr),
    .stride_i      (stride),
    .len_i         (len),
    .busy_o        (busy),
    .done_o        (done),
    .tcdm_req_o    (req),
    .tcdm_gnt_i    (gnt),
    .tcdm_add_o    (add),
    .tcdm_wen_o    (wen),
    .tcdm_be_o     (be),
    .tcdm_data_o   (wdata),
    .tcdm_r_data_i (r_data),
    .tcdm_r_valid_i(r_valid),
    .data_o        (data),
    .valid_o       (valid),
    .ready_i       (ready),
    .last_o        (last),
    .err_o         (err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[17:2], ~a[17:2]} ^ 32'h1357_9BDF;
  endfunction

  // Dummy memory: answers each grant in the following cycle, unless held.
  initial forever begin
    @(negedge clk); #2;
    if (!resp_hold && resp_q.size() > 0) begin
      r_data  = resp_q.pop_front();
      r_valid = 1'b1;
    end else begin
      r_data  = '0;
      r_valid = 1'b0;
    end
    if (req && gnt && !rst) resp_q.push_back(mem_word(add));
  end

  // Scoreboard: grant addresses and output beats are compared against the queued expectations.
  initial begin
    bit          stall_prev = 1'b0;
    logic [32:0] held = '0;
    logic [32:0] e;
    logic [31:0] a;
    forever begin
      @(negedge clk); #3;
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (req && gnt) begin
          grant_cnt++;
          tests_run++;
          if (exp_addr.size() == 0) begin
            tests_failed++;
            $display("FAIL grant_addr: unexpected grant at address %h, none required", add);
          end else begin
            a = exp_addr.pop_front();
            if (add !== a) begin
              tests_failed++;
              $display("FAIL grant_addr: got %h, required %h", add, a);
            end
          end
        end
        if (stall_prev) begin
          tests_run++;
          if (!valid || {last, data} !== held) begin
            tests_failed++;
            $display("FAIL stall_hold: valid=%b last/data=%h, required valid=1 last/data=%h", valid, {last, data}, held);
          end
        end
        if (valid && ready) begin
          tests_run++;
          if (exp_beat.size() == 0) begin
            tests_failed++;
            $display("FAIL stream_beat: unexpected beat last/data=%h", {last, data});
          end else begin
            e = exp_beat.pop_front();
            if ({last, data} !== e) begin
              tests_failed++;
              $display("FAIL stream_beat: got last/data=%h, required %h", {last, data}, e);
            end
          end
        end
        stall_prev = valid && !ready;
        held       = {last, data};
      end
    end
  end

  task automatic start_xfer(input logic [31:0] b, input logic [31:0] s, input logic [15:0] n);
    logic [31:0] a;
    a = b;
    for (int k = 0; k < int'(n); k++) begin
      exp_addr.push_back(a);
      exp_beat.push_back({(k == int'(n) - 1), mem_word(a)});
      a = a + s;
    end
    @(negedge clk);
    base_addr = b;
    stride    = s;
    len       = n;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output int cycles);
    got    = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, req, valid, last, err} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy/done/req/valid/last/err=%b, required 000000", {busy, done, req, valid, last, err});
    end
    tests_run++;
    if (add !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_addr: got %h, required 00000000", add);
    end
    tests_run++;
    if ({wen, be, wdata} !== {1'b1, 4'hF, 32'h0}) begin
      tests_failed++;
      $display("FAIL const_outputs: wen=%b be=%h wdata=%h, required 1 f 00000000", wen, be, wdata);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, req, valid} !== 3'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy/req/valid=%b, required 000", {busy, req, valid});
    end
  endtask

  task automatic test_basic();
    bit got;
    int cycles;
    gnt   = 1'b1;
    ready = 1'b1;
    start_xfer(32'h100, 32'd4, 16'd4);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_busy: got %b, required 1", busy);
    end
    wait_done(40, got, cycles);
    tests_run++;
    if (!got || cycles != 6) begin
      tests_failed++;
      $display("FAIL basic_done: seen=%0d after %0d cycles, required seen=1 after 6", got, cycles);
    end
    @(negedge clk);
    tests_run++;
    if ({done, busy, err} !== 3'b0 || exp_beat.size() != 0 || exp_addr.size() != 0) begin
      tests_failed++;
      $display("FAIL basic_end: done/busy/err=%b left beats=%0d addrs=%0d, required 000 0 0", {done, busy, err}, exp_beat.size(), exp_addr.size());
    end
  endtask

  task automatic test_grant_stall();
    bit got;
    int cycles;
    gnt   = 1'b1;
    ready = 1'b1;
    start_xfer(32'h100, 32'd4, 16'd4);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (req !== 1'b1 || add !== 32'h104) begin
        tests_failed++;
        $display("FAIL stall_req: cycle %0d req=%b add=%h, required req=1 add=00000104", i, req, add);
      end
      if (i == 0) gnt = 1'b0;
      @(negedge clk);
    end
    gnt = 1'b1;
    wait_done(40, got, cycles);
    tests_run++;
    if (!got || exp_beat.size() != 0 || exp_addr.size() != 0) begin
      tests_failed++;
      $display("FAIL stall_done: seen=%0d left beats=%0d addrs=%0d, required 1 0 0", got, exp_beat.size(), exp_addr.size());
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit got;
    int cycles;
    int g0;
    gnt   = 1'b1;
    ready = 1'b0;
    g0    = grant_cnt;
    start_xfer(32'h200, 32'd4, 16'd10);
    repeat (20) @(negedge clk);
    tests_run++;
    if (grant_cnt - g0 != FIFO_DEPTH || req !== 1'b0 || valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_credit: grants=%0d req=%b valid=%b, required grants=%0d req=0 valid=1", grant_cnt - g0, req, valid, FIFO_DEPTH);
    end
    ready = 1'b1;
    wait_done(80, got, cycles);
    tests_run++;
    if (!got || grant_cnt - g0 != 10 || exp_beat.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_release: seen=%0d grants=%0d left beats=%0d, required 1 10 0", got, grant_cnt - g0, exp_beat.size());
    end
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    int g0;
    gnt   = 1'b1;
    ready = 1'b1;
    g0    = grant_cnt;
    start_xfer(32'h400, 32'd4, 16'd0);
    tests_run++;
    if ({busy, done, req} !== 3'b110) begin
      tests_failed++;
      $display("FAIL zero_done: busy/done/req=%b, required 110", {busy, done, req});
    end
    @(negedge clk);
    tests_run++;
    if ({busy, done, req} !== 3'b000 || grant_cnt != g0) begin
      tests_failed++;
      $display("FAIL zero_after: busy/done/req=%b grants=%0d, required 000 0", {busy, done, req}, grant_cnt - g0);
    end
  endtask

  task automatic test_wrap();
    bit got;
    int cycles;
    gnt   = 1'b1;
    ready = 1'b1;
    start_xfer(32'hFFFF_FFF8, 32'd8, 16'd3);
    wait_done(40, got, cycles);
    tests_run++;
    if (!got || exp_addr.size() != 0 || exp_beat.size() != 0) begin
      tests_failed++;
      $display("FAIL wrap_done: seen=%0d left addrs=%0d beats=%0d, required 1 0 0", got, exp_addr.size(), exp_beat.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit got;
    int g0;
    logic exp_err;
`ifdef TCDM_STREAM_READER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    gnt       = 1'b1;
    ready     = 1'b0;
    resp_hold = 1'b1;
    g0        = grant_cnt;
    got       = 1'b0;
    start_xfer(32'h300, 32'd4, 16'd6);
    for (int i = 0; i < 20 && !got; i++) begin
      if (grant_cnt - g0 >= 2) got = 1'b1;
      else @(negedge clk);
    end
    gnt = 1'b0;
    tests_run++;
    if (!got || grant_cnt - g0 != 2) begin
      tests_failed++;
      $display("FAIL rst_mid_setup: grants=%0d, required 2", grant_cnt - g0);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({req, busy, valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst_mid_clear: req/busy/valid=%b, required 000", {req, busy, valid});
    end
    rst = 1'b0;
    exp_addr.delete();
    exp_beat.delete();
    resp_hold = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (valid !== 1'b0 || err !== exp_err) begin
      tests_failed++;
      $display("FAIL rst_mid_late: valid=%b err=%b, required valid=0 err=%b", valid, err, exp_err);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_grant_stall();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
